// File: rtl/t03_dpu_pkg.sv
// Shared definitions for the DPU register bridge: register offsets, field layout,
// FSM states and the commit-time clamp helpers.
package t03_dpu_pkg;

    localparam logic [4:0] OFF_GAME  = 5'h00;
    localparam logic [4:0] OFF_P1    = 5'h04;
    localparam logic [4:0] OFF_P2    = 5'h08;
    localparam logic [4:0] OFF_P1POS = 5'h0C;
    localparam logic [4:0] OFF_P2POS = 5'h10;
    localparam logic [4:0] OFF_CTRL  = 5'h14;
    localparam logic [4:0] OFF_STAT  = 5'h18;

    localparam int POS_X_LSB = 0;
    localparam int POS_Y_LSB = 16;
    localparam int COORD_W   = 11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        COMMIT = 2'd2
    } fsm_e;

    // Packed to match the P1/P2 register layout: [6] left, [5:2] health, [1:0] state.
    typedef struct packed {
        logic       left;
        logic [3:0] health;
        logic [1:0] state;
    } player_t;

    typedef struct packed {
        logic [10:0] y;
        logic [10:0] x;
    } pos_t;

    function automatic logic [3:0] clamp_health(input logic [3:0] h);
        return (h > 4'd9) ? 4'd9 : h;
    endfunction

    function automatic logic [10:0] clamp_coord(input logic [10:0] v, input logic [10:0] vmax);
        return (v > vmax) ? vmax : v;
    endfunction

    function automatic logic [2:0] clamp_game(input logic [2:0] g);
        return (g > 3'd4) ? 3'd0 : g;
    endfunction

endpackage

// File: rtl/t03_vsync_edge.sv
// Start-of-frame detector: registers vsync, flags its falling edge and counts frames.
module t03_vsync_edge
    import t03_dpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        vsync,
    output logic        fe,
    output logic [15:0] frame_cnt
);

    logic vsync_q_r;

    assign fe = vsync_q_r & ~vsync;

    // Delayed vsync and free-running frame counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_q_r <= 1'b1;
            frame_cnt <= 16'd0;
        end else begin
            vsync_q_r <= vsync;
            if (fe) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end

endmodule

// File: rtl/t03_dpu_reg_bridge.sv
// CPU register window that shadows the DPU game state and commits it at frame start.
// Define T03_DPU_BRIDGE_CLAMP_EN to clamp out-of-range values at commit time.
module t03_dpu_reg_bridge
    import t03_dpu_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'hFF00_0000,
    parameter logic [10:0] X_MAX     = 11'd639,
    parameter logic [10:0] Y_MAX     = 11'd479
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ack,
    input  logic        vsync,
    output logic [2:0]  gameState,
    output logic [1:0]  p1State,
    output logic [1:0]  p2State,
    output logic [3:0]  p1health,
    output logic [3:0]  p2health,
    output logic [10:0] x1,
    output logic [10:0] y1,
    output logic [10:0] x2,
    output logic [10:0] y2,
    output logic        p1Left,
    output logic        p2Left,
    output logic [15:0] frame_cnt
);

`ifdef T03_DPU_BRIDGE_CLAMP_EN
    localparam bit CLAMP_EN = 1'b1;
`else
    localparam bit CLAMP_EN = 1'b0;
`endif

    logic [31:0] off_s;
    logic        hit_s;
    logic        we_s;
    logic        re_s;
    logic        commit_req_s;
    logic        fe_s;
    logic [31:0] rd_val_s;
    logic        unused_wdata_s;

    logic [2:0]  game_sh_r;
    player_t     p1_sh_r;
    player_t     p2_sh_r;
    pos_t        p1pos_sh_r;
    pos_t        p2pos_sh_r;
    logic        auto_r;
    logic        pending_r;
    fsm_e        state_r;

    logic [2:0]  game_c_s;
    logic [3:0]  p1h_c_s;
    logic [3:0]  p2h_c_s;
    pos_t        p1pos_c_s;
    pos_t        p2pos_c_s;

    t03_vsync_edge u_vsync_edge (
        .clk       (clk),
        .rst_n     (rst),
        .vsync     (vsync),
        .fe        (fe_s),
        .frame_cnt (frame_cnt)
    );

    assign off_s          = addr - BASE_ADDR;
    assign hit_s          = (off_s[31:5] == 27'd0) && (addr[1:0] == 2'b00);
    assign we_s           = wr_en & hit_s;
    assign re_s           = rd_en & ~wr_en;
    assign commit_req_s   = we_s && (off_s[4:0] == OFF_CTRL) && wdata[0];
    assign unused_wdata_s = ^{wdata[31:27], wdata[15:11]};

    // Read-data mux; anything outside the window or misaligned reads as zero
    always_comb begin
        rd_val_s = 32'd0;
        if (hit_s) begin
            case (off_s[4:0])
                OFF_GAME:  rd_val_s = {29'd0, game_sh_r};
                OFF_P1:    rd_val_s = {25'd0, p1_sh_r};
                OFF_P2:    rd_val_s = {25'd0, p2_sh_r};
                OFF_P1POS: rd_val_s = {5'd0, p1pos_sh_r.y, 5'd0, p1pos_sh_r.x};
                OFF_P2POS: rd_val_s = {5'd0, p2pos_sh_r.y, 5'd0, p2pos_sh_r.x};
                OFF_CTRL:  rd_val_s = {30'd0, auto_r, pending_r};
                OFF_STAT:  rd_val_s = {16'd0, frame_cnt};
                default:   rd_val_s = 32'd0;
            endcase
        end else begin
            rd_val_s = 32'd0;
        end
    end

    // Commit-time values, optionally clamped; shadow readback always stays raw
    always_comb begin
        game_c_s  = game_sh_r;
        p1h_c_s   = p1_sh_r.health;
        p2h_c_s   = p2_sh_r.health;
        p1pos_c_s = p1pos_sh_r;
        p2pos_c_s = p2pos_sh_r;
        if (CLAMP_EN) begin
            game_c_s    = clamp_game(game_sh_r);
            p1h_c_s     = clamp_health(p1_sh_r.health);
            p2h_c_s     = clamp_health(p2_sh_r.health);
            p1pos_c_s.x = clamp_coord(p1pos_sh_r.x, X_MAX);
            p1pos_c_s.y = clamp_coord(p1pos_sh_r.y, Y_MAX);
            p2pos_c_s.x = clamp_coord(p2pos_sh_r.x, X_MAX);
            p2pos_c_s.y = clamp_coord(p2pos_sh_r.y, Y_MAX);
        end else begin
            game_c_s  = game_sh_r;
            p1pos_c_s = p1pos_sh_r;
            p2pos_c_s = p2pos_sh_r;
        end
    end

    // Bus response: one-cycle ack and registered read data
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ack   <= 1'b0;
            rdata <= 32'd0;
        end else begin
            ack   <= wr_en | rd_en;
            rdata <= re_s ? rd_val_s : 32'd0;
        end
    end

    // Shadow registers and the auto-commit enable
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            game_sh_r  <= 3'd0;
            p1_sh_r    <= '0;
            p2_sh_r    <= '0;
            p1pos_sh_r <= '0;
            p2pos_sh_r <= '0;
            auto_r     <= 1'b0;
        end else if (we_s) begin
            case (off_s[4:0])
                OFF_GAME:  game_sh_r  <= wdata[2:0];
                OFF_P1:    p1_sh_r    <= wdata[6:0];
                OFF_P2:    p2_sh_r    <= wdata[6:0];
                OFF_P1POS: p1pos_sh_r <= {wdata[POS_Y_LSB +: COORD_W], wdata[POS_X_LSB +: COORD_W]};
                OFF_P2POS: p2pos_sh_r <= {wdata[POS_Y_LSB +: COORD_W], wdata[POS_X_LSB +: COORD_W]};
                OFF_CTRL:  auto_r     <= wdata[1];
                default:   ;
            endcase
        end
    end

    // Commit FSM with the DPU-facing active registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= IDLE;
            pending_r <= 1'b0;
            gameState <= 3'd0;
            p1State   <= 2'd0;
            p2State   <= 2'd0;
            p1health  <= 4'd0;
            p2health  <= 4'd0;
            x1        <= 11'd0;
            y1        <= 11'd0;
            x2        <= 11'd0;
            y2        <= 11'd0;
            p1Left    <= 1'b0;
            p2Left    <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (commit_req_s) begin
                        state_r <= ARMED;
                    end else if (fe_s && auto_r) begin
                        state_r <= COMMIT;
                    end
                end
                ARMED: begin
                    if (fe_s) begin
                        state_r <= COMMIT;
                    end
                end
                COMMIT: begin
                    gameState <= game_c_s;
                    p1State   <= p1_sh_r.state;
                    p2State   <= p2_sh_r.state;
                    p1health  <= p1h_c_s;
                    p2health  <= p2h_c_s;
                    x1        <= p1pos_c_s.x;
                    y1        <= p1pos_c_s.y;
                    x2        <= p2pos_c_s.x;
                    y2        <= p2pos_c_s.y;
                    p1Left    <= p1_sh_r.left;
                    p2Left    <= p2_sh_r.left;
                    state_r   <= commit_req_s ? ARMED : IDLE;
                end
                default: state_r <= IDLE;
            endcase
            if (commit_req_s) begin
                pending_r <= 1'b1;
            end else if (state_r == COMMIT) begin
                pending_r <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_t03_dpu_reg_bridge.sv
// Directed bench for the DPU register bridge with hand-computed expectations.
module tb_t03_dpu_reg_bridge;

    localparam logic [31:0] A_GAME  = 32'hFF00_0000;
    localparam logic [31:0] A_P1    = 32'hFF00_0004;
    localparam logic [31:0] A_P2    = 32'hFF00_0008;
    localparam logic [31:0] A_P1POS = 32'hFF00_000C;
    localparam logic [31:0] A_P2POS = 32'hFF00_0010;
    localparam logic [31:0] A_CTRL  = 32'hFF00_0014;
    localparam logic [31:0] A_STAT  = 32'hFF00_0018;

`ifdef T03_DPU_BRIDGE_CLAMP_EN
    localparam logic [31:0] P1H_EXP = 32'd9;
`else
    localparam logic [31:0] P1H_EXP = 32'd12;
`endif

    logic        clk;
    logic        rst;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ack;
    logic        vsync;
    logic [2:0]  gameState;
    logic [1:0]  p1State;
    logic [1:0]  p2State;
    logic [3:0]  p1health;
    logic [3:0]  p2health;
    logic [10:0] x1;
    logic [10:0] y1;
    logic [10:0] x2;
    logic [10:0] y2;
    logic        p1Left;
    logic        p2Left;
    logic [15:0] frame_cnt;

    int tests_run    = 0;
    int tests_failed = 0;
    int frames_exp   = 0;

    t03_dpu_reg_bridge dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .rd_en     (rd_en),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .ack       (ack),
        .vsync     (vsync),
        .gameState (gameState),
        .p1State   (p1State),
        .p2State   (p2State),
        .p1health  (p1health),
        .p2health  (p2health),
        .x1        (x1),
        .y1        (y1),
        .x2        (x2),
        .y2        (y2),
        .p1Left    (p1Left),
        .p2Left    (p2Left),
        .frame_cnt (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outs_zero(input string tag);
        check_val({tag, "_ctl"}, 32'({gameState, p1State, p2State, p1health, p2health, p1Left, p2Left}), 32'd0);
        check_val({tag, "_pos1"}, 32'({x1, y1}), 32'd0);
        check_val({tag, "_pos2"}, 32'({x2, y2}), 32'd0);
        check_val({tag, "_bus"}, 32'({ack, rdata[30:0] | {30'd0, rdata[31]}}), 32'd0);
        check_val({tag, "_frames"}, 32'(frame_cnt), 32'd0);
    endtask

    // All bus tasks start and end 1 time unit after a rising edge
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        wr_en = 1'b1;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
        addr  = a;
        rd_en = 1'b1;
        @(posedge clk);
        #1;
        rd_en = 1'b0;
        check_val({tag, "_ack"}, 32'(ack), 32'd1);
        check_val(tag, rdata, exp);
    endtask

    task automatic frame();
        vsync = 1'b0;
        @(posedge clk);
        #1;
        vsync = 1'b1;
        @(posedge clk);
        #1;
        frames_exp++;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst   = 1'b1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        addr  = 32'd0;
        wdata = 32'd0;
        vsync = 1'b1;
        #2 rst = 1'b0;
        #10;
        check_outs_zero("reset");
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Reset in the middle of a read, after a commit made outputs non-zero
        bus_write(A_GAME, 32'd2);
        bus_write(A_CTRL, 32'd1);
        frame();
        check_val("game_before_rst", 32'(gameState), 32'd2);
        addr  = A_GAME;
        rd_en = 1'b1;
        @(posedge clk);
        #1;
        check_val("ack_before_rst", 32'(ack), 32'd1);
        #2 rst = 1'b0;
        #1;
        check_outs_zero("midrst");
        rd_en = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        frames_exp = 0;
        read_check("stat_after_rst", A_STAT, 32'd0);
        read_check("game_shadow_after_rst", A_GAME, 32'd0);

        // Requested commit with exact 2-edge latency
        bus_write(A_P1POS, 32'h0064_00C8);
        bus_write(A_CTRL, 32'd1);
        read_check("ctrl_pending", A_CTRL, 32'd1);
        vsync = 1'b0;
        @(posedge clk);
        #1;
        check_val("x1_one_edge", 32'(x1), 32'd0);
        vsync = 1'b1;
        @(posedge clk);
        #1;
        frames_exp++;
        check_val("x1_commit", 32'(x1), 32'd200);
        check_val("y1_commit", 32'(y1), 32'd100);
        check_val("frame_cnt_1", 32'(frame_cnt), 32'(frames_exp));
        read_check("ctrl_cleared", A_CTRL, 32'd0);

        // Health above 9; readback stays raw
        bus_write(A_P1, 32'h72);
        bus_write(A_CTRL, 32'd1);
        frame();
        check_val("p1health", 32'(p1health), P1H_EXP);
        check_val("p1state", 32'(p1State), 32'd2);
        check_val("p1left", 32'(p1Left), 32'd1);
        read_check("p1_readback", A_P1, 32'h72);

        // Shadow write during the COMMIT cycle waits for the next commit
        bus_write(A_GAME, 32'd1);
        bus_write(A_CTRL, 32'd1);
        vsync = 1'b0;
        @(posedge clk);
        #1;
        frames_exp++;
        vsync = 1'b1;
        bus_write(A_GAME, 32'd3);
        check_val("game_old_committed", 32'(gameState), 32'd1);
        bus_write(A_CTRL, 32'd1);
        frame();
        check_val("game_next_commit", 32'(gameState), 32'd3);

        // Commit request coinciding with fe arms for the following frame
        bus_write(A_GAME, 32'd4);
        vsync = 1'b0;
        bus_write(A_CTRL, 32'd1);
        frames_exp++;
        vsync = 1'b1;
        @(posedge clk);
        #1;
        check_val("game_req_on_fe", 32'(gameState), 32'd3);
        read_check("ctrl_armed", A_CTRL, 32'd1);
        frame();
        check_val("game_after_armed", 32'(gameState), 32'd4);

        // Unmapped, misaligned and simultaneous accesses
        read_check("unmapped_rd", 32'hFF00_0020, 32'd0);
        @(posedge clk);
        #1;
        check_val("ack_single_pulse", 32'(ack), 32'd0);
        read_check("misaligned_rd", 32'hFF00_0002, 32'd0);
        addr  = A_P1;
        wdata = 32'h05;
        wr_en = 1'b1;
        rd_en = 1'b1;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        check_val("wr_rd_rdata", rdata, 32'd0);
        check_val("wr_rd_ack", 32'(ack), 32'd1);
        read_check("wr_rd_wrote", A_P1, 32'h05);
        bus_write(32'hFF00_0006, 32'h7F);
        read_check("misaligned_wr", A_P1, 32'h05);
        bus_write(A_STAT, 32'h1234);
        read_check("stat_ro", A_STAT, 32'(frames_exp));

        // Auto mode: every frame commits
        bus_write(A_CTRL, 32'd2);
        read_check("ctrl_auto", A_CTRL, 32'd2);
        for (int i = 0; i < 3; i++) begin
            bus_write(A_P2POS, 32'((i + 10) << 16) | 32'(i * 100 + 5));
            bus_write(A_P2, 32'((i + 1) << 2));
            frame();
            check_val($sformatf("auto_x2_%0d", i), 32'(x2), 32'(i * 100 + 5));
            check_val($sformatf("auto_y2_%0d", i), 32'(y2), 32'(i + 10));
            check_val($sformatf("auto_p2h_%0d", i), 32'(p2health), 32'(i + 1));
        end
        bus_write(A_CTRL, 32'd0);
        check_val("frame_cnt_pre_wrap", 32'(frame_cnt), 32'(frames_exp));

        // Hold vsync_q high with vsync low so every cycle is a falling edge
        force dut.u_vsync_edge.vsync_q_r = 1'b1;
        vsync = 1'b0;
        repeat (65535 - frames_exp) @(posedge clk);
        #1;
        check_val("frame_cnt_max", 32'(frame_cnt), 32'hFFFF);
        @(posedge clk);
        #1;
        check_val("frame_cnt_wrap", 32'(frame_cnt), 32'd0);
        vsync = 1'b1;
        release dut.u_vsync_edge.vsync_q_r;
        @(posedge clk);
        #1;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
